// File: rtl/alu_cdb_if.sv
// alu_cdb_if: issue bus from the RS and ALU CDB broadcast bus
// master: RS/arbiter side drives issue + grant, observes backpressure and broadcast
// slave : alu_cdb_unit side
interface alu_cdb_if #(parameter int TAGW = 4);
  logic            flag_alu;
  logic [5:0]      op_alu;
  logic [31:0]     rs1_alu;
  logic [31:0]     rs2_alu;
  logic [TAGW-1:0] rob_alu;
  logic            cdb_grant;
  logic            alu_full;
  logic            alu_ovf;
  logic            alu_ans_flag;
  logic [TAGW-1:0] alu_ans_reorder;
  logic [31:0]     alu_ans;
  modport master (
    output flag_alu, op_alu, rs1_alu, rs2_alu, rob_alu, cdb_grant,
    input  alu_full, alu_ovf, alu_ans_flag, alu_ans_reorder, alu_ans
  );
  modport slave (
    input  flag_alu, op_alu, rs1_alu, rs2_alu, rob_alu, cdb_grant,
    output alu_full, alu_ovf, alu_ans_flag, alu_ans_reorder, alu_ans
  );
endinterface

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: single-cycle ALU/branch/JALR execute stage with in-order result FIFO feeding the ALU CDB slot
// Ports: clk, rst (sync, active high), rdy (low = freeze), clr (flush), bus (alu_cdb_if.slave:
//   issue flag/op/rs1/rs2/rob, cdb_grant in; alu_full, alu_ovf, alu_ans_flag/reorder/ans out)
// Optional: define ALU_BYPASS_EN to let an issue go straight to the CDB when the FIFO is empty and granted
module alu_cdb_unit #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic clr,
  alu_cdb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_FULL  = (AW+1)'(DEPTH - 1);
  logic [TAGW+31:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             r_flag, r_ovf;
  logic [TAGW-1:0]  r_tag;
  logic [31:0]      r_ans;
  logic [31:0]      w_res;
  logic [4:0]       w_sh;
  logic             w_lt, w_ltu, w_eq;
  logic             w_go, w_empty, w_pop, w_byp, w_push, w_drop;
  assign w_sh  = bus.rs2_alu[4:0];
  assign w_lt  = $signed(bus.rs1_alu) < $signed(bus.rs2_alu);
  assign w_ltu = bus.rs1_alu < bus.rs2_alu;
  assign w_eq  = bus.rs1_alu == bus.rs2_alu;
  always_comb begin
    w_res = '0;
    case (bus.op_alu)
      6'd0:  w_res = bus.rs1_alu + bus.rs2_alu;
      6'd1:  w_res = bus.rs1_alu - bus.rs2_alu;
      6'd2:  w_res = bus.rs1_alu << w_sh;
      6'd3:  w_res = {31'b0, w_lt};
      6'd4:  w_res = {31'b0, w_ltu};
      6'd5:  w_res = bus.rs1_alu ^ bus.rs2_alu;
      6'd6:  w_res = bus.rs1_alu >> w_sh;
      6'd7:  w_res = $unsigned($signed(bus.rs1_alu) >>> w_sh);
      6'd8:  w_res = bus.rs1_alu | bus.rs2_alu;
      6'd9:  w_res = bus.rs1_alu & bus.rs2_alu;
      6'd10: w_res = {31'b0, w_eq};
      6'd11: w_res = {31'b0, !w_eq};
      6'd12: w_res = {31'b0, w_lt};
      6'd13: w_res = {31'b0, !w_lt};
      6'd14: w_res = {31'b0, w_ltu};
      6'd15: w_res = {31'b0, !w_ltu};
      6'd16: w_res = (bus.rs1_alu + bus.rs2_alu) & ~32'd1;
      default: w_res = '0;
    endcase
  end
  assign w_go    = rdy && !clr;
  assign w_empty = r_cnt == '0;
  assign w_pop   = w_go && !w_empty && bus.cdb_grant;
`ifdef ALU_BYPASS_EN
  assign w_byp   = w_go && w_empty && bus.cdb_grant && bus.flag_alu;
`else
  assign w_byp   = 1'b0;
`endif
  // a same-edge pop frees the slot, so a full FIFO can still accept
  assign w_push  = w_go && bus.flag_alu && !w_byp && (r_cnt != L_DEPTH || w_pop);
  assign w_drop  = w_go && bus.flag_alu && r_cnt == L_DEPTH && !w_pop;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {bus.rob_alu, w_res};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
      r_tag  <= '0;
      r_ans  <= '0;
      r_ovf  <= 1'b0;
    end else if (!rdy) begin
      r_flag <= 1'b0;
    end else if (clr) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_wp   <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp   <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_flag <= w_pop || w_byp;
      r_ovf  <= r_ovf || w_drop;
      if (w_pop) {r_tag, r_ans} <= r_mem[r_rp];
      else if (w_byp) {r_tag, r_ans} <= {bus.rob_alu, w_res};
    end
  end
  assign bus.alu_full        = r_cnt >= L_FULL;
  assign bus.alu_ovf         = r_ovf;
  assign bus.alu_ans_flag    = r_flag;
  assign bus.alu_ans_reorder = r_tag;
  assign bus.alu_ans         = r_ans;
endmodule

// File: tb/tb_alu_cdb_unit.sv
// tb_alu_cdb_unit: directed test-plan scenarios plus randomized traffic checked against a queue-based reference model
module tb_alu_cdb_unit;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
`ifdef ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
  int checks = 0, errors = 0;
  alu_cdb_if #(.TAGW(TAGW)) bus ();
  alu_cdb_unit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  logic [TAGW+31:0] m_q[$];
  logic             m_flag = 1'b0, m_ovf = 1'b0;
  logic [TAGW-1:0]  m_tag = '0;
  logic [31:0]      m_ans = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_res(int op, logic [31:0] a, logic [31:0] b);
    int sh = int'(b % 32);
    logic [63:0] ext = {{32{a[31]}}, a};
    bit slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    bit ult = a < b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * (32'd1 << sh);
      3: return slt ? 1 : 0;
      4: return ult ? 1 : 0;
      5: return a ^ b;
      6: return a / (32'd1 << sh);
      7: return ext[31+sh -: 32];
      8: return a | b;
      9: return a & b;
      10: return (a == b) ? 1 : 0;
      11: return (a != b) ? 1 : 0;
      12: return slt ? 1 : 0;
      13: return slt ? 0 : 1;
      14: return ult ? 1 : 0;
      15: return ult ? 0 : 1;
      16: return (a + b) - ((a + b) % 2);
      default: return 0;
    endcase
  endfunction
  task automatic model();
    logic [TAGW+31:0] e;
    bit byp;
    if (rst) begin
      m_q.delete(); m_flag = 0; m_tag = '0; m_ans = '0; m_ovf = 0;
    end else if (!rdy) begin
      m_flag = 0;
    end else if (clr) begin
      m_q.delete(); m_flag = 0;
    end else begin
      byp = BYP && m_q.size() == 0 && bus.cdb_grant && bus.flag_alu;
      m_flag = 0;
      if (m_q.size() > 0 && bus.cdb_grant) begin
        e = m_q.pop_front(); {m_tag, m_ans} = e; m_flag = 1;
      end else if (byp) begin
        m_tag = bus.rob_alu; m_ans = ref_res(int'(bus.op_alu), bus.rs1_alu, bus.rs2_alu); m_flag = 1;
      end
      if (bus.flag_alu && !byp) begin
        if (m_q.size() < DEPTH) m_q.push_back({bus.rob_alu, ref_res(int'(bus.op_alu), bus.rs1_alu, bus.rs2_alu)});
        else m_ovf = 1;
      end
    end
  endtask
  task automatic tick();
    model();
    @(posedge clk);
    #1;
    chk("flag", 32'(bus.alu_ans_flag), 32'(m_flag));
    chk("tag", 32'(bus.alu_ans_reorder), 32'(m_tag));
    chk("ans", bus.alu_ans, m_ans);
    chk("ovf", 32'(bus.alu_ovf), 32'(m_ovf));
    chk("full", 32'(bus.alu_full), 32'(m_q.size() >= DEPTH - 1));
  endtask
  task automatic drive(bit f, int op, logic [31:0] a, logic [31:0] b, int tag, bit g);
    bus.flag_alu = f; bus.op_alu = 6'(op); bus.rs1_alu = a; bus.rs2_alu = b;
    bus.rob_alu = TAGW'(tag); bus.cdb_grant = g;
  endtask
  task automatic issue_expect(string name, int op, logic [31:0] a, logic [31:0] b, int tag, logic [31:0] exp);
    bit seen = 0;
    int lat = 0;
    drive(1, op, a, b, tag, 1);
    tick();
    lat = 1;
    drive(0, 0, 0, 0, 0, 1);
    while (!bus.alu_ans_flag && lat < 5) begin
      tick();
      lat++;
    end
    if (bus.alu_ans_flag) begin
      seen = 1;
      chk(name, bus.alu_ans, exp);
      chk({name, "_tag"}, 32'(bus.alu_ans_reorder), 32'(tag));
      chk({name, "_lat"}, 32'(lat), BYP ? 32'd1 : 32'd2);
    end
    if (!seen) chk({name, "_timeout"}, 32'(seen), 32'd1);
    tick();
    chk({name, "_onepulse"}, 32'(bus.alu_ans_flag), 32'd0);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 0;
    chk("rst_flag", 32'(bus.alu_ans_flag), 32'd0);
    chk("rst_full", 32'(bus.alu_full), 32'd0);
    issue_expect("add", 0, 5, 7, 3, 32'd12);
    issue_expect("sub", 1, 0, 1, 4, 32'hFFFF_FFFF);
    issue_expect("sra", 7, 32'h8000_0000, 4, 5, 32'hF800_0000);
    issue_expect("slt", 3, 32'hFFFF_FFFF, 1, 6, 32'd1);
    issue_expect("sltu", 4, 32'hFFFF_FFFF, 1, 7, 32'd0);
    issue_expect("bgeu", 15, 2, 3, 8, 32'd0);
    issue_expect("jalr", 16, 32'h1001, 4, 9, 32'h1004);
    issue_expect("badop", 40, 3, 4, 10, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 32'(i), 0, i, 0);
      tick();
      if (i == 3) chk("bp_full3", 32'(bus.alu_full), 32'd1);
    end
    chk("bp_ovf", 32'(bus.alu_ovf), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("bp_order", 32'(bus.alu_ans_reorder), 32'(i));
    end
    rst = 1; tick(); rst = 0;
    chk("rst_ovf", 32'(bus.alu_ovf), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 32'(i), 32'd100, i, 0);
      tick();
    end
    drive(1, 0, 32'd5, 32'd100, 5, 1);
    tick();
    chk("pp_ovf", 32'(bus.alu_ovf), 32'd0);
    chk("pp_full", 32'(bus.alu_full), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("pp_order", 32'(bus.alu_ans_reorder), 32'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5, 32'(i), 32'hA5, i, 0);
      tick();
    end
    clr = 1;
    drive(1, 0, 1, 1, 9, 1);
    tick();
    clr = 0;
    chk("clr_full", 32'(bus.alu_full), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_nobc", 32'(bus.alu_ans_flag), 32'd0);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(1, 8, 32'(i), 32'h10, i, 0);
      tick();
    end
    rdy = 0;
    drive(1, 0, 7, 7, 7, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy0_nobc", 32'(bus.alu_ans_flag), 32'd0);
    end
    rdy = 1;
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("rdy_resume", 32'(bus.alu_ans_reorder), 32'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 32'(i), 0, i, i == 1);
      tick();
    end
    rst = 1; tick(); rst = 0;
    chk("mid_rst_ans", bus.alu_ans, 32'd0);
    chk("mid_rst_full", 32'(bus.alu_full), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("mid_rst_empty", 32'(bus.alu_ans_flag), 32'd0);
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      rdy = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 39) == 0;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 20),
            $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 9)),
            $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 9)),
            $urandom_range(0, (1 << TAGW) - 1), $urandom_range(0, 2) != 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
